// File: rtl/signed_divider_pkg.sv
// signed_divider_pkg: widths, FSM states and saturation bounds for signed_divider24.
package signed_divider_pkg;
    localparam int DIVIDEND_W = 24;
    localparam int DIVISOR_W  = 9;
    localparam int QUOTIENT_W = 15;
    localparam int REM_W      = DIVISOR_W + 1;
    localparam int CNT_W      = $clog2(DIVIDEND_W);
    localparam int QMAX       = 2 ** (QUOTIENT_W - 1) - 1;
    localparam int QMIN       = -(2 ** (QUOTIENT_W - 1));
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step (shift in a dividend bit, trial subtract, restore).
module div_step
    import signed_divider_pkg::*;
(
    input  logic [REM_W-1:0]     rem,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] dvs,
    output logic [REM_W-1:0]     rem_next,
    output logic                 q_bit
);
    logic [REM_W:0] sh, dx;
    always_comb begin
        sh       = {rem, bit_in};
        dx       = (REM_W + 1)'(dvs);
        q_bit    = sh >= dx;
        rem_next = REM_W'(q_bit ? sh - dx : sh);
    end
endmodule

// File: rtl/signed_divider24.sv
// signed_divider24: iterative 24/9 signed restoring divider, 15-bit saturated quotient.
module signed_divider24
    import signed_divider_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [QUOTIENT_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  overflow,
    output logic                  div_by_zero
);
    state_t state, state_next;
    logic [CNT_W-1:0]      cnt;
    logic [DIVIDEND_W-1:0] acc;
    logic [REM_W-1:0]      rem, rem_next;
    logic [DIVISOR_W-1:0]  dvs, r_fix;
    logic                  dneg, qneg, dz, q_bit, hi, lo;
    logic signed [DIVIDEND_W:0] q_full;

    div_step u_step (.rem(rem), .bit_in(acc[DIVIDEND_W-1]), .dvs(dvs), .rem_next(rem_next), .q_bit(q_bit));

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_next;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = (divisor == '0) ? FIX : CALC;
            CALC: if (cnt == '0) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CALC) || (state == FIX);
        done = state == DONE;
    end

    // Quotient is range-checked at full width so saturation sees true magnitude.
    always_comb begin
        q_full = qneg ? -$signed({1'b0, acc}) : $signed({1'b0, acc});
        hi     = int'(q_full) > QMAX;
        lo     = int'(q_full) < QMIN;
        r_fix  = DIVISOR_W'(dneg ? -rem : rem);
    end

    // acc holds |dividend| and shifts quotient bits in from the right.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            acc         <= '0;
            rem         <= '0;
            dvs         <= '0;
            dneg        <= 1'b0;
            qneg        <= 1'b0;
            dz          <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                acc  <= dividend[DIVIDEND_W-1] ? -dividend : dividend;
                dvs  <= divisor[DIVISOR_W-1] ? -divisor : divisor;
                rem  <= '0;
                cnt  <= CNT_W'(DIVIDEND_W - 1);
                dneg <= dividend[DIVIDEND_W-1];
                qneg <= dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
                dz   <= divisor == '0;
            end
            if (state == CALC) begin
                acc <= {acc[DIVIDEND_W-2:0], q_bit};
                rem <= rem_next;
                cnt <= cnt - 1'b1;
            end
            if (state == FIX) begin
                quotient    <= dz ? '0 : hi ? QUOTIENT_W'(QMAX) : lo ? QUOTIENT_W'(QMIN) : q_full[QUOTIENT_W-1:0];
                remainder   <= dz ? '0 : r_fix;
                overflow    <= !dz && (hi || lo);
                div_by_zero <= dz;
            end
        end
    end
endmodule

// File: tb/tb_signed_divider24.sv
// tb_signed_divider24: directed and random operations against an integer-arithmetic model.
module tb_signed_divider24;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        start = 1'b0;
    logic [23:0] dividend = '0;
    logic [8:0]  divisor = '0;
    logic        busy, done, overflow, div_by_zero;
    logic [14:0] quotient;
    logic [8:0]  remainder;
    int          checks = 0;
    int          failures = 0;
    time         last_done = 0;

    signed_divider24 dut (
        .clock(clock), .reset_n(reset_n), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .overflow(overflow), .div_by_zero(div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic run_op(input int x, input int y, input bit poke);
        int q, r, ov, dz, n, nb, lat;
        dz = int'(y == 0);
        ov = 0;
        q = 0;
        r = 0;
        if (!dz) begin
            q = x / y;
            r = x % y;
        end
        if (q > 16383) begin q = 16383; ov = 1; end
        else if (q < -16384) begin q = -16384; ov = 1; end
        lat = dz ? 2 : 26;
        @(negedge clock);
        start = 1'b1;
        dividend = 24'(x);
        divisor = 9'(y);
        n = 0;
        while (!busy && n < 40) begin
            @(posedge clock); #1;
            n++;
        end
        check("accept", int'(busy), 1);
        start = 1'b0;
        n = 1;
        nb = 1;
        while (!done && n < 60) begin
            @(posedge clock); #1;
            n++;
            if (poke && n == 5) begin
                start = 1'b1;
                dividend = 24'h000123;
                divisor = 9'd3;
            end else start = 1'b0;
            if (busy) nb++;
        end
        start = 1'b0;
        last_done = $time;
        check("done", int'(done), 1);
        check("latency", n, lat);
        check("busy_cycles", nb, lat - 1);
        check("quotient", int'($signed(quotient)), q);
        check("remainder", int'($signed(remainder)), r);
        check("overflow", int'(overflow), ov);
        check("div_by_zero", int'(div_by_zero), dz);
    endtask

    task automatic check_cleared();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_quotient", int'(quotient), 0);
        check("rst_remainder", int'(remainder), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_div_by_zero", int'(div_by_zero), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        time t1;
        int nd;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_cleared();
        @(negedge clock);
        reset_n = 1'b1;

        run_op(1000, 7, 0);
        run_op(-1000, 7, 0);
        run_op(1000, -7, 0);
        run_op(-1000, -7, 0);
        run_op(8388607, 1, 0);
        run_op(-8388608, -1, 0);
        run_op(-16384, 1, 0);
        run_op(16383, 1, 0);
        run_op(-8388608, -256, 0);
        run_op(8388607, -256, 0);
        run_op(255, 256, 0);
        run_op(-255, -256, 0);
        run_op(12345, 0, 0);
        run_op(-5, 0, 0);
        run_op(1000, 7, 1);

        run_op(5000, -13, 0);
        t1 = last_done;
        run_op(-77777, 100, 0);
        check("back_to_back", int'((last_done - t1) / 10), 27);

        run_op(-8388608, 3, 0);
        @(negedge clock);
        start = 1'b1;
        dividend = 24'd1000;
        divisor = 9'd7;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check_cleared();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        nd = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done) nd++;
        end
        check("no_done_after_reset", nd, 0);
        run_op(1000, 7, 0);

        for (int i = 0; i < 40; i++) begin
            int x, y;
            x = int'($signed(24'($urandom)));
            y = (i % 2 == 0) ? $urandom_range(20) - 10 : int'($signed(9'($urandom)));
            run_op(x, y, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
